cpu_ctrl_seq: RTL and testbench

- Fetch/decode/execute sequencer for the 16-bit CPU.
- Drives the program counter's load/increment controls and the instruction-register capture.
- Drives ALU/register-file strobes and a req/ack data-memory handshake.
- Sits between InsROM output and the datapath; the only block allowed to move the PC.

---
 rtl/cpu_ctrl_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq.sv
// ============================================================================
// Module   : cpu_ctrl_seq
// Purpose  : Fetch/decode/execute sequencer for the 16-bit CPU. Sole owner of
//            the program counter controls; captures the instruction, strobes
//            the ALU and register file, and runs a req/ack data-memory
//            handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FETCH_LAT   cycles held in FETCH before instr is valid (1..7)
//   TRAP_VEC    PC target for an illegal opcode (trap build only)
// Build option
//   CTRL_ILLEGAL_TRAP_EN  defined  : illegal opcodes trap to TRAP_VEC and set
//                                    the sticky illegal_o flag
//                         undefined: illegal opcodes act as NOP, illegal_o=0
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   instr_i         instruction word from InsROM (sampled on ir_load_o)
//   zero_flag_i     ALU zero flag, used by JZ in EXEC
//   mem_ack_i       data-memory acknowledge pulse
//   pc_load_o/pc_inc_o/pc_target_o  PC control: 00 clear, 10 load, 01 inc,
//                                   11 hold
//   ir_load_o       instruction-register capture strobe
//   alu_en_o/alu_op_o/reg_we_o      ALU and register-file strobes
//   mem_req_o/mem_we_o/mem_addr_o   data-memory request
//   halted_o, illegal_o, state_o    status / debug
// ============================================================================
`default_nettype none

module cpu_ctrl_seq #(
  parameter int unsigned FETCH_LAT = 2,
  parameter logic [15:0] TRAP_VEC  = 16'h0FF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_i,
  input  logic        zero_flag_i,
  input  logic        mem_ack_i,
  output logic        pc_load_o,
  output logic        pc_inc_o,
  output logic [15:0] pc_target_o,
  output logic        ir_load_o,
  output logic        alu_en_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_we_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [11:0] mem_addr_o,
  output logic        halted_o,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] C_OP_NOP   = 4'd0;
  localparam logic [3:0] C_OP_LOAD  = 4'd1;
  localparam logic [3:0] C_OP_STORE = 4'd2;
  localparam logic [3:0] C_OP_ADD   = 4'd3;
  localparam logic [3:0] C_OP_SUB   = 4'd4;
  localparam logic [3:0] C_OP_JMP   = 4'd5;
  localparam logic [3:0] C_OP_JZ    = 4'd6;
  localparam logic [3:0] C_OP_HALT  = 4'd7;

  localparam logic [2:0] C_FETCH_LAST = 3'(FETCH_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  opcode_q;
  logic [11:0] operand_q;
  logic        w_illegal_op;

  // Opcodes 8..15 are the illegal half of the opcode space.
  assign w_illegal_op = opcode_q[3];

  // --------------------------------------------------------------------------
  // State, fetch-wait counter and latched instruction
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RST;
      cnt_q     <= 3'd0;
      opcode_q  <= 4'd0;
      operand_q <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ir_load_o) begin
        opcode_q  <= instr_i[15:12];
        operand_q <= instr_i[11:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (cnt_q == C_FETCH_LAST) begin
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode_q)
          C_OP_LOAD, C_OP_STORE: state_d = S_MEM;
          C_OP_HALT:             state_d = S_HALT;
          default:               state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ack_i) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: combinational from registered state and latched instruction.
  // pc_target_o is only meaningful on a load; it is parked at the trap vector
  // otherwise so the idle value is a harmless constant.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_load_o   = 1'b1;
    pc_inc_o    = 1'b1;
    pc_target_o = TRAP_VEC;
    ir_load_o   = 1'b0;
    alu_en_o    = 1'b0;
    alu_op_o    = 2'b00;
    reg_we_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 12'd0;
    halted_o    = 1'b0;
    case (state_q)
      S_RST: begin
        pc_load_o = 1'b0;
        pc_inc_o  = 1'b0;
      end
      S_FETCH: ir_load_o = (cnt_q == C_FETCH_LAST);
      S_EXEC: begin
        case (opcode_q)
          C_OP_NOP: pc_load_o = 1'b0;
          C_OP_ADD, C_OP_SUB: begin
            alu_en_o  = 1'b1;
            alu_op_o  = (opcode_q == C_OP_SUB) ? 2'b01 : 2'b00;
            reg_we_o  = 1'b1;
            pc_load_o = 1'b0;
          end
          C_OP_JMP: begin
            pc_inc_o    = 1'b0;
            pc_target_o = {4'h0, operand_q};
          end
          C_OP_JZ: begin
            if (zero_flag_i) begin
              pc_inc_o    = 1'b0;
              pc_target_o = {4'h0, operand_q};
            end else begin
              pc_load_o = 1'b0;
            end
          end
          C_OP_LOAD, C_OP_STORE, C_OP_HALT: ;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            pc_inc_o    = 1'b0;
            pc_target_o = TRAP_VEC;
`else
            pc_load_o = 1'b0;
`endif
          end
        endcase
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        mem_addr_o = operand_q;
        mem_we_o   = (opcode_q == C_OP_STORE);
        if (mem_ack_i) begin
          reg_we_o  = (opcode_q == C_OP_LOAD);
          pc_load_o = 1'b0;
        end
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky illegal-opcode flag
  // --------------------------------------------------------------------------
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_EXEC && w_illegal_op) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_o = illegal_q;
`else
  // Decoded but only consumed by the trap build.
  logic w_unused;
  assign w_unused  = w_illegal_op;
  assign illegal_o = 1'b0;
`endif

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
// ============================================================================
// Module   : tb_cpu_ctrl_seq
// Purpose  : Scoreboard bench for cpu_ctrl_seq. A ROM/PC model feeds the DUT;
//            directed programs push the expected output events into a queue
//            and a negedge monitor pops and compares every cycle in which the
//            DUT drives an active control (non-hold PC, strobe or mem_req).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl_seq;

  logic        clk;
  logic        rst;
  logic [15:0] instr_i;
  logic        zero_flag_i;
  logic        mem_ack_i;
  logic        pc_load_o, pc_inc_o;
  logic [15:0] pc_target_o;
  logic        ir_load_o, alu_en_o, reg_we_o;
  logic [1:0]  alu_op_o;
  logic        mem_req_o, mem_we_o;
  logic [11:0] mem_addr_o;
  logic        halted_o, illegal_o;
  logic [2:0]  state_o;

  cpu_ctrl_seq #(.FETCH_LAT(2), .TRAP_VEC(16'h0FF0)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .zero_flag_i(zero_flag_i),
    .mem_ack_i(mem_ack_i), .pc_load_o(pc_load_o), .pc_inc_o(pc_inc_o),
    .pc_target_o(pc_target_o), .ir_load_o(ir_load_o), .alu_en_o(alu_en_o),
    .alu_op_o(alu_op_o), .reg_we_o(reg_we_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .halted_o(halted_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM / PC model ----------------
  logic [15:0] rom [0:255];
  logic        zf  [0:255];
  logic [15:0] pc;
  int          ack_delay;
  int          ack_cnt;

  assign instr_i     = rom[pc[7:0]];
  assign zero_flag_i = zf[pc[7:0]];

  always @(posedge clk) begin
    case ({pc_load_o, pc_inc_o})
      2'b00: pc <= 16'd0;
      2'b10: pc <= pc_target_o;
      2'b01: pc <= pc + 16'd1;
      default: pc <= pc;
    endcase
  end

  // Memory responder: ack on the ack_delay-th cycle of a request.
  always @(posedge clk) begin
    #1;
    if (mem_req_o && !rst) begin
      mem_ack_i = (ack_cnt == ack_delay);
      ack_cnt   = ack_cnt + 1;
    end else begin
      mem_ack_i = 1'b0;
      ack_cnt   = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [40:0] exp_q [$];
  logic        exp_ill;

  function automatic logic [40:0] ev(input logic [2:0] st, input logic [1:0] pcc,
                                     input logic [15:0] tgt, input logic ir,
                                     input logic alu, input logic [1:0] op,
                                     input logic we, input logic req,
                                     input logic mwe, input logic [11:0] addr,
                                     input logic ill);
    return {st, pcc, tgt, ir, alu, op, we, req, mwe, addr, ill};
  endfunction

  // Don't-care fields are masked: target only on a load, op only with alu_en,
  // address/direction only while requesting.
  function automatic logic [40:0] observed();
    return ev(state_o, {pc_load_o, pc_inc_o},
              ({pc_load_o, pc_inc_o} == 2'b10) ? pc_target_o : 16'h0000,
              ir_load_o, alu_en_o, alu_en_o ? alu_op_o : 2'b00, reg_we_o,
              mem_req_o, mem_req_o ? mem_we_o : 1'b0,
              mem_req_o ? mem_addr_o : 12'h000, illegal_o);
  endfunction

  always @(negedge clk) begin
    logic [40:0] got, want;
    if (!rst && (({pc_load_o, pc_inc_o} != 2'b11) || ir_load_o || alu_en_o ||
                 reg_we_o || mem_req_o)) begin
      got = observed();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h required no event", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_event: got %h required %h (t=%0t)", got, want, $time);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic push_rst();   exp_q.push_back(ev(3'd0, 2'b00, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'h0, exp_ill)); endtask
  task automatic push_fetch(); exp_q.push_back(ev(3'd1, 2'b11, 16'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'h0, exp_ill)); endtask
  task automatic push_inc();   exp_q.push_back(ev(3'd3, 2'b01, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'h0, exp_ill)); endtask
  task automatic push_alu(input logic [1:0] op);
    exp_q.push_back(ev(3'd3, 2'b01, 16'h0, 1'b0, 1'b1, op, 1'b1, 1'b0, 1'b0, 12'h0, exp_ill));
  endtask
  task automatic push_jump(input logic [15:0] tgt);
    exp_q.push_back(ev(3'd3, 2'b10, tgt, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 12'h0, exp_ill));
  endtask
  task automatic push_mem(input int waits, input logic store, input logic [11:0] addr);
    for (int i = 0; i < waits; i++)
      exp_q.push_back(ev(3'd4, 2'b11, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, store, addr, exp_ill));
    exp_q.push_back(ev(3'd4, 2'b01, 16'h0, 1'b0, 1'b0, 2'b00, !store, 1'b1, store, addr, exp_ill));
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h7000;
      zf[i]  = 1'b0;
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input string name, input logic [15:0] want_pc, input logic want_ill);
    int n = 0;
    while (!halted_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halt_reached"}, {31'd0, halted_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({name, "_halt_hold"}, {27'd0, state_o, pc_load_o, pc_inc_o}, {27'd0, 3'd5, 2'b11});
    end
    check({name, "_pc"}, {16'd0, pc}, {16'd0, want_pc});
    check({name, "_illegal"}, {31'd0, illegal_o}, {31'd0, want_ill});
    check({name, "_sb_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed programs ----------------
  initial begin
    int n;
    rst = 1'b1;
    mem_ack_i = 1'b0;
    ack_cnt = 0;
    ack_delay = 0;
    exp_ill = 1'b0;
    pc = 16'd0;
    load_rom();

    // Program 1: NOP, NOP, HALT
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h7000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {16'd0, state_o, pc_load_o, pc_inc_o, ir_load_o, alu_en_o,
                            reg_we_o, mem_req_o, halted_o, illegal_o},
          32'd0);
    check("reset_pc", {16'd0, pc}, 32'd0);
    push_rst();
    push_fetch(); push_inc();
    push_fetch(); push_inc();
    push_fetch();
    release_reset();
    wait_halt("p1", 16'd2, 1'b0);

    // Program 2: ADD, SUB, LOAD, STORE, JZ (not taken), JZ (taken), illegal, HALT
    enter_reset();
    load_rom();
    rom[0] = 16'h3000; rom[1] = 16'h4000;
    rom[2] = 16'h1123; rom[3] = 16'h2045;
    rom[4] = 16'h6040; zf[4] = 1'b0;
    rom[5] = 16'h6040; zf[5] = 1'b1;
    rom[8'h40] = 16'hA000; rom[8'h41] = 16'h7000;
    rom[8'hF0] = 16'h7000;
    ack_delay = 3;
    exp_ill = 1'b0;
    push_rst();
    push_fetch(); push_alu(2'b00);
    push_fetch(); push_alu(2'b01);
    push_fetch(); push_mem(3, 1'b0, 12'h123);
    push_fetch(); push_mem(3, 1'b1, 12'h045);
    push_fetch(); push_inc();
    push_fetch(); push_jump(16'h0040);
    push_fetch();
`ifdef CTRL_ILLEGAL_TRAP_EN
    push_jump(16'h0FF0);
    exp_ill = 1'b1;
    push_fetch();
    release_reset();
    wait_halt("p2", 16'h0FF0, 1'b1);
`else
    push_inc();
    push_fetch();
    release_reset();
    wait_halt("p2", 16'h0041, 1'b0);
`endif

    // Program 3: reset in the middle of a stalled LOAD, then restart
    enter_reset();
    load_rom();
    rom[0] = 16'h1010; rom[1] = 16'h7000;
    ack_delay = 100;
    exp_ill = 1'b0;
    push_rst();
    push_fetch();
    push_mem(3, 1'b0, 12'h010);
    void'(exp_q.pop_back());   // the ack never comes before the abort
    release_reset();
    n = 0;
    while (!mem_req_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("p3_mem_req_seen", {31'd0, mem_req_o}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("p3_abort_req", {31'd0, mem_req_o}, 32'd0);
    check("p3_abort_state", {29'd0, state_o}, 32'd0);
    check("p3_sb_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("p3_pc_cleared", {16'd0, pc}, 32'd0);
    ack_delay = 0;
    push_rst();
    push_fetch(); push_mem(0, 1'b0, 12'h010);
    push_fetch();
    release_reset();
    wait_halt("p3", 16'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
